// File: rtl/sobel_stream_ctrl.sv
// Streaming 3x3 Sobel engine: raster pixels in over valid/ready, |Gx|+|Gy| out per interior pixel.
// Optional feature macro: SOBEL_BINARIZE_EN (output thresholded to all-ones / zero against THRESHOLD).
module sobel_stream_ctrl #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMAGE_WIDTH  = 64,
    parameter int IMAGE_HEIGHT = 48,
    parameter int THRESHOLD    = 128
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [PIXEL_WIDTH-1:0] in_px_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [PIXEL_WIDTH-1:0] out_px_o,
    output logic                   out_last_o,
    output logic                   busy_o,
    output logic                   frame_done_o
);
    localparam int SW = PIXEL_WIDTH + 4;
    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);

    if (IMAGE_WIDTH < 3 || IMAGE_HEIGHT < 3 || THRESHOLD < 0) begin : g_bad_cfg
        $error("sobel_stream_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          last_px;
    logic          produce;

    // lb1 holds the previous line, lb2 the line before it
    logic [PIXEL_WIDTH-1:0] lb1 [IMAGE_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb2 [IMAGE_WIDTH];

    // Two stored window columns per row; the third is the incoming column
    logic [PIXEL_WIDTH-1:0] win_top [2];
    logic [PIXEL_WIDTH-1:0] win_mid [2];
    logic [PIXEL_WIDTH-1:0] win_bot [2];

    logic [PIXEL_WIDTH-1:0] p00, p01, p02, p10, p12, p20, p21, p22;
    logic signed [SW-1:0]   gx, gy;
    logic [SW-1:0]          ax, ay, mag;
    logic [PIXEL_WIDTH-1:0] res;

    assign accept  = in_valid_i & in_ready_o;
    assign last_px = (row == RW'(IMAGE_HEIGHT - 1)) && (col == CW'(IMAGE_WIDTH - 1));
    assign produce = (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_ready_o   = 1'b0;
        busy_o       = 1'b0;
        frame_done_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy_o     = 1'b1;
                in_ready_o = !out_valid_o || out_ready_i;
                if (accept && last_px) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (out_valid_o && out_ready_i && out_last_o) state_nxt = S_DONE;
            end
            S_DONE: begin
                frame_done_o = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            row <= '0;
            col <= '0;
        end else if (state == S_IDLE && start_i) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == CW'(IMAGE_WIDTH - 1)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb2[col]   <= lb1[col];
            lb1[col]   <= in_px_i;
            win_top[0] <= win_top[1];
            win_top[1] <= lb2[col];
            win_mid[0] <= win_mid[1];
            win_mid[1] <= lb1[col];
            win_bot[0] <= win_bot[1];
            win_bot[1] <= in_px_i;
        end
    end

    always_comb begin
        p00 = win_top[0];
        p01 = win_top[1];
        p02 = lb2[col];
        p10 = win_mid[0];
        p12 = lb1[col];
        p20 = win_bot[0];
        p21 = win_bot[1];
        p22 = in_px_i;

        gx = ($signed(SW'(p02)) + ($signed(SW'(p12)) <<< 1) + $signed(SW'(p22)))
           - ($signed(SW'(p00)) + ($signed(SW'(p10)) <<< 1) + $signed(SW'(p20)));
        gy = ($signed(SW'(p20)) + ($signed(SW'(p21)) <<< 1) + $signed(SW'(p22)))
           - ($signed(SW'(p00)) + ($signed(SW'(p01)) <<< 1) + $signed(SW'(p02)));

        ax  = gx[SW-1] ? SW'(-gx) : SW'(gx);
        ay  = gy[SW-1] ? SW'(-gy) : SW'(gy);
        mag = ax + ay;

`ifdef SOBEL_BINARIZE_EN
        res = (mag >= SW'(THRESHOLD)) ? '1 : '0;
`else
        res = (|mag[SW-1:PIXEL_WIDTH]) ? '1 : mag[PIXEL_WIDTH-1:0];
`endif
    end

    // A new result may load in the same edge as the downstream handshake
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_valid_o <= 1'b0;
            out_px_o    <= '0;
            out_last_o  <= 1'b0;
        end else if (accept && produce) begin
            out_valid_o <= 1'b1;
            out_px_o    <= res;
            out_last_o  <= last_px;
        end else if (out_valid_o && out_ready_i) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// Self-checking bench for sobel_stream_ctrl on a 5x4 frame against a spec-level Sobel model.
module tb_sobel_stream_ctrl;
    localparam int PW   = 8;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int THR  = 16;
    localparam int N    = W * H;
    localparam int NOUT = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_px;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_px;
    logic          out_last;
    logic          busy;
    logic          frame_done;

    int            n_cmp = 0;
    int            n_err = 0;
    int            frame [N];
    logic [PW:0]   exp_q [$];
    logic [PW:0]   got [$];
    int            done_cnt = 0;

    always #5 clk = ~clk;

    sobel_stream_ctrl #(
        .PIXEL_WIDTH (PW),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .THRESHOLD   (THR)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .start_i     (start),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_px_i     (in_px),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_px_o    (out_px),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .frame_done_o(frame_done)
    );

    // Inputs change #1 after posedge, so the negedge view predicts the next edge's handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) got.push_back({out_last, out_px});
            if (frame_done) done_cnt++;
        end
    end

    function automatic int pix(input int r, input int c);
        return frame[r * W + c];
    endfunction

    function automatic void build_expected();
        exp_q.delete();
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                int gx, gy, mag;
                logic [PW-1:0] v;
                gx = (pix(r-1, c+1) + 2 * pix(r, c+1) + pix(r+1, c+1))
                   - (pix(r-1, c-1) + 2 * pix(r, c-1) + pix(r+1, c-1));
                gy = (pix(r+1, c-1) + 2 * pix(r+1, c) + pix(r+1, c+1))
                   - (pix(r-1, c-1) + 2 * pix(r-1, c) + pix(r-1, c+1));
                mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_BINARIZE_EN
                v = (mag >= THR) ? '1 : '0;
`else
                v = (mag > 255) ? 8'd255 : PW'(mag);
`endif
                exp_q.push_back({(r == H - 2 && c == W - 2), v});
            end
        end
    endfunction

    task automatic fill_cols(input int c0, input int c1, input int c2, input int c3, input int c4);
        int cv [5];
        cv = '{c0, c1, c2, c3, c4};
        for (int i = 0; i < N; i++) frame[i] = cv[i % W];
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(255));
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_pixels(input int count, input int gap_pct, input int start_at,
                                output int sent);
        int cyc;
        sent = 0;
        cyc  = 0;
        while (sent < count && cyc < 2000) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_px    = PW'(frame[sent]);
            start    = (sent == start_at);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input int gap_pct, input int start_at, output int sent);
        got.delete();
        done_cnt = 0;
        build_expected();
        start_frame();
        drive_pixels(N, gap_pct, start_at, sent);
        wait_done();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_cmp++;
        if ({in_ready, out_valid, out_px, out_last, busy, frame_done} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %b want all zero",
                     {in_ready, out_valid, out_px, out_last, busy, frame_done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, busy, out_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset got %b want 000", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_uniform();
        int sent;
        fill_cols(50, 50, 50, 50, 50);
        got.delete();
        done_cnt = 0;
        build_expected();
        start_frame();
        @(negedge clk);
        n_cmp++;
        if ({busy, in_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL uniform_busy got %b want 11", {busy, in_ready});
        end
        drive_pixels(N, 0, -1, sent);
        wait_done();
        n_cmp++;
        if (got.size() !== NOUT) begin
            n_err++;
            $display("FAIL uniform_count got %0d want %0d", got.size(), NOUT);
        end
        for (int i = 0; i < got.size() && i < NOUT; i++) begin
            n_cmp++;
            if (got[i] !== {(i == NOUT - 1), 8'd0}) begin
                n_err++;
                $display("FAIL uniform_px[%0d] got %h want %h", i, got[i], {(i == NOUT - 1), 8'd0});
            end
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL uniform_done_pulse got %0d cycles want 1", done_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL uniform_idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_vertical_edge();
        int sent;
        logic [PW-1:0] pat [3];
        pat = '{8'd255, 8'd255, 8'd0};
        fill_cols(0, 0, 100, 100, 100);
        run_frame(0, -1, sent);
        n_cmp++;
        if (got.size() !== NOUT) begin
            n_err++;
            $display("FAIL vedge_count got %0d want %0d", got.size(), NOUT);
        end
        for (int i = 0; i < got.size() && i < NOUT; i++) begin
            n_cmp++;
            if (got[i] !== {(i == NOUT - 1), pat[i % 3]}) begin
                n_err++;
                $display("FAIL vedge_px[%0d] got %h want %h", i, got[i], {(i == NOUT - 1), pat[i % 3]});
            end
        end
    endtask

    task automatic test_ramp();
        int sent;
        logic [PW-1:0] pat [3];
`ifdef SOBEL_BINARIZE_EN
        pat = '{8'd255, 8'd255, 8'd0};
`else
        pat = '{8'd20, 8'd20, 8'd0};
`endif
        fill_cols(0, 0, 5, 5, 5);
        run_frame(0, -1, sent);
        n_cmp++;
        if (got.size() !== NOUT) begin
            n_err++;
            $display("FAIL ramp_count got %0d want %0d", got.size(), NOUT);
        end
        for (int i = 0; i < got.size() && i < NOUT; i++) begin
            n_cmp++;
            if (got[i] !== {(i == NOUT - 1), pat[i % 3]}) begin
                n_err++;
                $display("FAIL ramp_px[%0d] got %h want %h", i, got[i], {(i == NOUT - 1), pat[i % 3]});
            end
        end
    endtask

    task automatic test_random_gaps();
        int sent;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame(50, -1, sent);
            n_cmp++;
            if (sent !== N || got.size() !== exp_q.size() || done_cnt !== 1) begin
                n_err++;
                $display("FAIL gaps_frame%0d sent %0d outs %0d done %0d want %0d/%0d/1",
                         f, sent, got.size(), done_cnt, N, exp_q.size());
            end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL gaps_px f%0d[%0d] got %h want %h", f, i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int sent;
        int t;
        fill_random();
        got.delete();
        done_cnt = 0;
        build_expected();
        out_ready = 1'b0;
        start_frame();
        fork
            drive_pixels(N, 0, -1, sent);
            begin
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                repeat (6) begin
                    n_cmp++;
                    if ({out_valid, in_ready, out_last, out_px} !== {1'b1, 1'b0, exp_q[0]}) begin
                        n_err++;
                        $display("FAIL stall_hold got v%b r%b %h want v1 r0 %h",
                                 out_valid, in_ready, {out_last, out_px}, exp_q[0]);
                    end
                    @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_done();
        n_cmp++;
        if (got.size() !== exp_q.size() || done_cnt !== 1) begin
            n_err++;
            $display("FAIL stall_count outs %0d done %0d want %0d/1", got.size(), done_cnt, exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL stall_px[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int sent;
        fill_random();
        start_frame();
        drive_pixels(7, 0, -1, sent);
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({busy, out_valid, in_ready, frame_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_outputs got %b want 0000", {busy, out_valid, in_ready, frame_done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        fill_random();
        run_frame(0, 8, sent);
        n_cmp++;
        if (sent !== N || got.size() !== exp_q.size() || done_cnt !== 1) begin
            n_err++;
            $display("FAIL midreset_frame sent %0d outs %0d done %0d want %0d/%0d/1",
                     sent, got.size(), done_cnt, N, exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL midreset_px[%0d] got %h want %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent;
        for (int f = 0; f < 2; f++) begin
            fill_random();
            run_frame(0, -1, sent);
            n_cmp++;
            if (got.size() !== exp_q.size() || done_cnt !== 1) begin
                n_err++;
                $display("FAIL b2b_count f%0d outs %0d done %0d want %0d/1",
                         f, got.size(), done_cnt, exp_q.size());
            end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL b2b_px f%0d[%0d] got %h want %h", f, i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        start     = 1'b0;
        in_valid  = 1'b0;
        in_px     = '0;
        out_ready = 1'b1;
        test_reset();
        test_uniform();
        test_vertical_edge();
        test_ramp();
        test_random_gaps();
        test_stall();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
